// File: rtl/mio_bus_responder.sv
// rtl/mio_bus_responder.sv - target-side memory/IO responder: RAM with wait states, switches, LED, counter
module mio_bus_responder #(
  parameter int RAM_AW   = 10,
  parameter int RAM_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CPU_MIO,
  input  logic              mem_w,
  input  logic [31:0]       Addr_in,
  input  logic [31:0]       Data_from_cpu,
  output logic [31:0]       Data_to_cpu,
  output logic              MIO_ready,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout,
  input  logic [15:0]       sw,
  output logic [15:0]       led,
  output logic              bus_err
);

  typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_WAIT, S_CAPTURE, S_DONE} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(RAM_WAIT);

  state_t      state, next_state;
  logic        wr_q;
  logic [3:0]  wait_cnt;
  logic [31:0] counter;
  logic [31:0] rd_data;
  logic        is_ram, is_sw, is_led, is_cnt, is_err;
  logic        unused_addr_bits;

  // Byte-lane bits carry no meaning on this word-wide bus.
  assign unused_addr_bits = ^Addr_in[1:0];

  assign is_ram = (Addr_in[31:28] == 4'h0);
  assign is_sw  = (Addr_in[31:2] == 30'h38000000);
  assign is_led = (Addr_in[31:2] == 30'h3C000000);
  assign is_cnt = (Addr_in[31:2] == 30'h3C000001);
  assign is_err = !(is_ram || is_sw || is_led || is_cnt);

  always_comb begin
    rd_data = 32'h0;
    if (is_sw)       rd_data = {16'h0, sw};
    else if (is_led) rd_data = {16'h0, led};
    else if (is_cnt) rd_data = counter;
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    MIO_ready  = 1'b0;
    ram_we     = 1'b0;
    case (state)
      S_IDLE:    if (CPU_MIO) next_state = is_ram ? S_ACCESS : S_DONE;
      S_ACCESS: begin
        ram_we     = wr_q;
        next_state = (RAM_WAIT == 0) ? S_CAPTURE : S_WAIT;
      end
      S_WAIT:    if (wait_cnt <= 4'd1) next_state = S_CAPTURE;
      S_CAPTURE: next_state = S_DONE;
      S_DONE: begin
        MIO_ready  = 1'b1;
        next_state = S_IDLE;
      end
      default:   next_state = S_IDLE;
    endcase
  end

  // Peripheral side effects and read capture happen on the acceptance edge itself.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q        <= 1'b0;
      wait_cnt    <= 4'd0;
      counter     <= 32'h0;
      led         <= 16'h0;
      bus_err     <= 1'b0;
      Data_to_cpu <= 32'h0;
      ram_addr    <= '0;
      ram_din     <= 32'h0;
    end else begin
      counter <= counter + 32'd1;
      case (state)
        S_IDLE: if (CPU_MIO) begin
          wr_q     <= mem_w;
          ram_addr <= Addr_in[RAM_AW+1:2];
          ram_din  <= Data_from_cpu;
          if (is_err) bus_err <= 1'b1;
          if (!is_ram) begin
            if (mem_w) begin
              if (is_led) led     <= Data_from_cpu[15:0];
              if (is_cnt) counter <= Data_from_cpu;
            end else begin
              Data_to_cpu <= rd_data;
            end
          end
        end
        S_ACCESS:  wait_cnt <= WAIT_INIT;
        S_WAIT:    wait_cnt <= wait_cnt - 4'd1;
        S_CAPTURE: if (!wr_q) Data_to_cpu <= ram_dout;
        default: ;
      endcase
    end
  end

endmodule
